// File: rtl/cfg_arb_pkg.sv
// Shared definitions for the configuration-space arbiter: state encoding,
// default bus widths and small sizing helpers.
package cfg_arb_pkg;

  localparam int DEF_DATA_WD = 32;
  localparam int DEF_ADDR_WD = 16;
  localparam int STRB_WD     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Bits needed for a counter that must be able to hold 'limit'.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

  // Bits needed to index 'n' requesters.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_space_arbiter_if.sv
// Requester-side and config-space-side signals of the arbiter.
// The arbiter uses the master view (it masters the config-space port);
// the surrounding environment uses the slave view.
interface cfg_space_arbiter_if
  import cfg_arb_pkg::*;
#(
  parameter int DATA_WD = DEF_DATA_WD,
  parameter int ADDR_WD = DEF_ADDR_WD,
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]         REQ;
  logic [NUM_REQ-1:0]         REQ_WRITE;
  logic [NUM_REQ*ADDR_WD-1:0] REQ_ADDR;
  logic [NUM_REQ*DATA_WD-1:0] REQ_DATA;
  logic [NUM_REQ*STRB_WD-1:0] REQ_STRB;
  logic [NUM_REQ-1:0]         GRANT;
  logic [NUM_REQ-1:0]         ACK;
  logic [NUM_REQ-1:0]         VALID;
  logic [DATA_WD-1:0]         RDATA;
  logic                       TMO_ERR;

  logic                       CS_REQ;
  logic                       CS_WRITE;
  logic [ADDR_WD-1:0]         CS_ADDR;
  logic [DATA_WD-1:0]         CS_WDATA;
  logic [STRB_WD-1:0]         CS_STRB;
  logic                       CS_ACK;
  logic                       CS_VALID;
  logic [DATA_WD-1:0]         CS_RDATA;

  modport master (
    input  REQ, REQ_WRITE, REQ_ADDR, REQ_DATA, REQ_STRB,
    output GRANT, ACK, VALID, RDATA, TMO_ERR,
    output CS_REQ, CS_WRITE, CS_ADDR, CS_WDATA, CS_STRB,
    input  CS_ACK, CS_VALID, CS_RDATA
  );

  modport slave (
    output REQ, REQ_WRITE, REQ_ADDR, REQ_DATA, REQ_STRB,
    input  GRANT, ACK, VALID, RDATA, TMO_ERR,
    input  CS_REQ, CS_WRITE, CS_ADDR, CS_WDATA, CS_STRB,
    output CS_ACK, CS_VALID, CS_RDATA
  );

endinterface

// File: rtl/cfg_space_arbiter_rr_picker.sv
// Round-robin picker: selects the first requesting index at or after the
// pointer, wrapping around. Purely combinational.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               any
);

  // Index reached by stepping 'off' positions past 'p', modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Scan from farthest to nearest so the last hit is the closest to the pointer.
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap(ptr, i)]) pick_idx = wrap(ptr, i);
    end
  end

  assign any  = |req;
  assign pick = any ? (NUM_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/cfg_space_arbiter.sv
// Round-robin arbiter and sequencer for the shared configuration-space port.
// One requester is granted at a time; its command is latched and presented
// to config space until CS_ACK or the timeout watchdog ends the transaction,
// then the completion is returned to that requester for one cycle.
module cfg_space_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int DATA_WD     = DEF_DATA_WD,
  parameter int ADDR_WD     = DEF_ADDR_WD,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                 S_CLK,
  input logic                 PRESETn,
  cfg_space_arbiter_if.master bus
);

  localparam int PTR_W = idx_width(NUM_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic             TMO_EN    = (TIMEOUT_CYC > 0);

  arb_state_t state, state_nxt;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   idx;
  logic [NUM_REQ-1:0] sel;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  logic [CNT_W-1:0]   tmo_cnt;
  logic               tmo_hit;

  logic [NUM_REQ-1:0] grant, ack, valid;
  logic [DATA_WD-1:0] rdata;
  logic               tmo_err;
  logic               cs_req, cs_write;
  logic [ADDR_WD-1:0] cs_addr;
  logic [DATA_WD-1:0] cs_wdata;
  logic [STRB_WD-1:0] cs_strb;

  // Per-requester views of the flattened command buses.
  logic [ADDR_WD-1:0] addr_arr [NUM_REQ];
  logic [DATA_WD-1:0] data_arr [NUM_REQ];
  logic [STRB_WD-1:0] strb_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.REQ_ADDR[g*ADDR_WD +: ADDR_WD];
    assign data_arr[g] = bus.REQ_DATA[g*DATA_WD +: DATA_WD];
    assign strb_arr[g] = bus.REQ_STRB[g*STRB_WD +: STRB_WD];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req      (bus.REQ),
    .ptr      (ptr),
    .pick     (pick_onehot),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Watchdog expiry; a simultaneous CS_ACK takes precedence downstream.
  assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LIMIT);

  // State register.
  always_ff @(posedge S_CLK) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.CS_ACK || tmo_hit) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Winner selection, grant pulse and round-robin pointer advance.
  always_ff @(posedge S_CLK) begin
    if (!PRESETn) begin
      ptr   <= '0;
      idx   <= '0;
      sel   <= '0;
      grant <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            idx   <= pick_idx;
            sel   <= pick_onehot;
            grant <= pick_onehot;
          end
        end
        ST_GRANT: grant <= '0;
        ST_RESP:  ptr <= (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Command register: captured at the end of the grant cycle, held through WAIT.
  always_ff @(posedge S_CLK) begin
    if (!PRESETn) begin
      cs_req   <= 1'b0;
      cs_write <= 1'b0;
      cs_addr  <= '0;
      cs_wdata <= '0;
      cs_strb  <= '0;
    end else begin
      case (state)
        ST_GRANT: begin
          cs_req   <= 1'b1;
          cs_write <= bus.REQ_WRITE[idx];
          cs_addr  <= addr_arr[idx];
          cs_wdata <= data_arr[idx];
          cs_strb  <= strb_arr[idx];
        end
        ST_WAIT: if (bus.CS_ACK || tmo_hit) cs_req <= 1'b0;
        default: ;
      endcase
    end
  end

  // Timeout counter: zero on WAIT entry, counts every WAIT cycle.
  always_ff @(posedge S_CLK) begin
    if (!PRESETn)               tmo_cnt <= '0;
    else if (state == ST_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
    else                        tmo_cnt <= '0;
  end

  // Response register: one-cycle completion to the granted requester.
  always_ff @(posedge S_CLK) begin
    if (!PRESETn) begin
      ack     <= '0;
      valid   <= '0;
      rdata   <= '0;
      tmo_err <= 1'b0;
    end else begin
      ack     <= '0;
      valid   <= '0;
      rdata   <= '0;
      tmo_err <= 1'b0;
      if (state == ST_WAIT) begin
        if (bus.CS_ACK) begin
          ack   <= sel;
          valid <= bus.CS_VALID ? sel : '0;
          rdata <= bus.CS_VALID ? bus.CS_RDATA : '0;
        end else if (tmo_hit) begin
          ack     <= sel;
          tmo_err <= 1'b1;
        end
      end
    end
  end

  assign bus.GRANT    = grant;
  assign bus.ACK      = ack;
  assign bus.VALID    = valid;
  assign bus.RDATA    = rdata;
  assign bus.TMO_ERR  = tmo_err;
  assign bus.CS_REQ   = cs_req;
  assign bus.CS_WRITE = cs_write;
  assign bus.CS_ADDR  = cs_addr;
  assign bus.CS_WDATA = cs_wdata;
  assign bus.CS_STRB  = cs_strb;

endmodule

// File: tb/tb_cfg_space_arbiter.sv
// Randomized bench for cfg_space_arbiter with a transaction-level reference
// model: round-robin choice over pending requesters, expected command, and
// expected completion time/contents from the chosen CS_ACK latency.
module tb_cfg_space_arbiter;
  import cfg_arb_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int NR  = 4;
  localparam int TMO = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cfg_space_arbiter_if #(.DATA_WD(DW), .ADDR_WD(AW), .NUM_REQ(NR)) bus ();

  cfg_space_arbiter #(
    .DATA_WD     (DW),
    .ADDR_WD     (AW),
    .NUM_REQ     (NR),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .S_CLK   (clk),
    .PRESETn (rstn),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model state: pending requests, their commands, and the priority pointer.
  logic [NR-1:0] req_v;
  logic [NR-1:0] hold;
  logic          cmd_wr   [NR];
  logic [AW-1:0] cmd_addr [NR];
  logic [DW-1:0] cmd_data [NR];
  logic [3:0]    cmd_strb [NR];
  int            model_ptr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Spec rule: first pending requester at or after the pointer, wrapping.
  function automatic int model_pick();
    for (int k = 0; k < NR; k++)
      if (req_v[(model_ptr + k) % NR]) return (model_ptr + k) % NR;
    return -1;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < NR; i++) begin
      bus.REQ[i]                = req_v[i];
      bus.REQ_WRITE[i]          = cmd_wr[i];
      bus.REQ_ADDR[i*AW +: AW]  = cmd_addr[i];
      bus.REQ_DATA[i*DW +: DW]  = cmd_data[i];
      bus.REQ_STRB[i*4 +: 4]    = cmd_strb[i];
    end
  endtask

  task automatic arm(input int i, input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [3:0] s, input logic h);
    req_v[i]    = 1'b1;
    hold[i]     = h;
    cmd_wr[i]   = wr;
    cmd_addr[i] = a;
    cmd_data[i] = d;
    cmd_strb[i] = s;
  endtask

  task automatic scramble(input int i);
    cmd_wr[i]   = 1'($urandom);
    cmd_addr[i] = AW'($urandom);
    cmd_data[i] = $urandom;
    cmd_strb[i] = 4'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_grant"}, 64'(bus.GRANT), 0);
    chk({tag, "_ack"}, 64'(bus.ACK), 0);
    chk({tag, "_valid"}, 64'(bus.VALID), 0);
    chk({tag, "_rdata"}, 64'(bus.RDATA), 0);
    chk({tag, "_tmo"}, 64'(bus.TMO_ERR), 0);
    chk({tag, "_csreq"}, 64'(bus.CS_REQ), 0);
  endtask

  // One full transaction, entered in an IDLE cycle with requests driven.
  // L = WAIT-cycle index (0 = first CS_REQ cycle) in which CS_ACK is driven.
  task automatic do_txn(input int L, input logic vld, input logic [DW-1:0] rd);
    int exp_idx, exp_lat, n;
    logic tmo;
    logic [52:0] e_cmd;

    exp_idx = model_pick();
    chk("model_has_req", 64'(exp_idx >= 0), 1);
    if (exp_idx < 0) return;
    tmo     = (L > TMO);
    exp_lat = (tmo ? TMO : L) + 1;
    e_cmd   = {cmd_wr[exp_idx], cmd_strb[exp_idx], cmd_addr[exp_idx], cmd_data[exp_idx]};

    // CS_ACK noise while not in WAIT must be ignored.
    bus.CS_ACK   = 1'($urandom);
    bus.CS_VALID = 1'($urandom);
    bus.CS_RDATA = $urandom;
    tick();
    chk("grant", 64'(bus.GRANT), 64'(oh(exp_idx)));
    chk("ack_in_grant", 64'(bus.ACK), 0);
    chk("csreq_in_grant", 64'(bus.CS_REQ), 0);
    if (!hold[exp_idx]) req_v[exp_idx] = 1'b0;
    drive_bus();
    bus.CS_ACK = 1'($urandom);
    tick();

    n = 0;
    while (n < 40) begin
      if (n < exp_lat) begin
        chk("cs_req", 64'(bus.CS_REQ), 1);
        chk("cs_cmd", 64'({bus.CS_WRITE, bus.CS_STRB, bus.CS_ADDR, bus.CS_WDATA}), 64'(e_cmd));
      end
      if (n == 0 && !hold[exp_idx]) begin
        scramble(exp_idx);
        drive_bus();
      end
      bus.CS_ACK   = (n == L);
      bus.CS_VALID = (n == L) ? vld : 1'($urandom);
      bus.CS_RDATA = (n == L) ? rd : $urandom;
      tick();
      n++;
      if (bus.ACK != '0) break;
    end

    chk("ack_latency", 64'(n), 64'(exp_lat));
    chk("ack", 64'(bus.ACK), 64'(oh(exp_idx)));
    chk("valid", 64'(bus.VALID), (!tmo && vld) ? 64'(oh(exp_idx)) : 0);
    chk("rdata", 64'(bus.RDATA), (!tmo && vld) ? 64'(rd) : 0);
    chk("tmo_err", 64'(bus.TMO_ERR), 64'(tmo));
    chk("csreq_in_resp", 64'(bus.CS_REQ), 0);
    bus.CS_ACK   = 1'($urandom);
    bus.CS_VALID = 1'($urandom);
    tick();
    chk("ack_one_cycle", 64'(bus.ACK), 0);
    chk("valid_one_cycle", 64'(bus.VALID), 0);
    chk("rdata_one_cycle", 64'(bus.RDATA), 0);
    chk("tmo_one_cycle", 64'(bus.TMO_ERR), 0);
    bus.CS_ACK = 1'b0;
    model_ptr = (exp_idx + 1) % NR;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.CS_ACK = 1'b0;
    repeat (2) tick();
    chk("rst_grant", 64'(bus.GRANT), 0);
    chk("rst_csreq", 64'(bus.CS_REQ), 0);
    rstn = 1'b1;
    model_ptr = 0;
  endtask

  initial begin
    req_v = '0;
    hold  = '0;
    for (int i = 0; i < NR; i++) begin
      cmd_wr[i] = 1'b0; cmd_addr[i] = '0; cmd_data[i] = '0; cmd_strb[i] = '0;
    end
    drive_bus();
    bus.CS_ACK   = 1'b0;
    bus.CS_VALID = 1'b0;
    bus.CS_RDATA = '0;
    model_ptr    = 0;

    // Reset state: every output zero.
    rstn = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    chk("reset_cs_fields", 64'({bus.CS_WRITE, bus.CS_STRB, bus.CS_ADDR, bus.CS_WDATA}), 0);
    rstn = 1'b1;

    // No requests: no grant, no CS activity.
    repeat (3) begin
      tick();
      chk("idle_grant", 64'(bus.GRANT), 0);
      chk("idle_csreq", 64'(bus.CS_REQ), 0);
    end

    // Single write from requester 1.
    arm(1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0);
    drive_bus();
    do_txn(2, 1'b0, 32'h0);

    // Single read from requester 2.
    arm(2, 1'b0, 16'h0020, 32'h0, 4'h0, 1'b0);
    drive_bus();
    do_txn(1, 1'b1, 32'h12345678);

    // Round robin from reset: all held -> 0,1,2,3,0; then only 0 and 3 -> 3.
    do_reset();
    for (int i = 0; i < NR; i++) arm(i, 1'($urandom), AW'($urandom), $urandom, 4'($urandom), 1'b1);
    drive_bus();
    for (int k = 0; k < 5; k++) begin
      chk("rr_order_model", 64'(model_pick()), 64'(k % NR));
      do_txn(0, 1'b0, 32'h0);
    end
    req_v[1] = 1'b0;
    req_v[2] = 1'b0;
    drive_bus();
    chk("rr_skip_model", 64'(model_pick()), 3);
    do_txn(1, 1'b1, $urandom);

    // Timeout: CS_ACK never comes; then the next requester is served.
    req_v = '0; hold = '0;
    arm(3, 1'b0, 16'h0300, 32'h0, 4'h0, 1'b0);
    drive_bus();
    do_txn(100, 1'b1, 32'hFFFF_FFFF);
    arm(0, 1'b1, 16'h0400, 32'hA5A5_5A5A, 4'h3, 1'b0);
    drive_bus();
    do_txn(3, 1'b0, 32'h0);

    // Collision: CS_ACK in the expiry cycle completes normally.
    arm(1, 1'b0, 16'h0500, 32'h0, 4'h0, 1'b0);
    drive_bus();
    do_txn(TMO, 1'b1, 32'hCAFE_F00D);

    // Reset in the middle of WAIT: outputs cleared, no ACK, requester 0 first.
    for (int i = 0; i < NR; i++) arm(i, 1'($urandom), AW'($urandom), $urandom, 4'($urandom), 1'b1);
    drive_bus();
    bus.CS_ACK = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset_csreq", 64'(bus.CS_REQ), 1);
    rstn = 1'b0;
    tick();
    check_idle_outputs("midwait_reset");
    chk("midwait_cs_fields", 64'({bus.CS_WRITE, bus.CS_STRB, bus.CS_ADDR, bus.CS_WDATA}), 0);
    rstn = 1'b1;
    model_ptr = 0;
    do_txn(0, 1'b1, $urandom);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (($urandom % 8) == 0) hold[i] = 1'b0;
        if (!req_v[i] && ($urandom % 2) == 0)
          arm(i, 1'($urandom), AW'($urandom), $urandom, 4'($urandom), (($urandom % 4) == 0));
      end
      if (req_v == '0) begin
        int r;
        r = int'($urandom_range(0, NR - 1));
        arm(r, 1'($urandom), AW'($urandom), $urandom, 4'($urandom), 1'b0);
      end
      drive_bus();
      do_txn(int'($urandom_range(0, 11)), 1'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
